counter_bus_port: RTL

- Counter-side responder to the internal address/control bus driven by the read/write logic.
- One instance per counter (C0, C1, C2).
- Decodes control words and data accesses addressed to its counter, and programs the counter's mode.
- Assembles 16-bit count-register writes from byte accesses, and serves count/status reads through the output latch, status latch and LSB/MSB byte sequencing.

---
 rtl/counter_bus_port_if.sv | 27 ++
 rtl/counter_bus_port.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_bus_port_if.sv
// Internal address/control bus between the read/write logic (master) and a counter port (slave).
interface counter_bus_port_if;
  logic       Access;
  logic [1:0] Add_bus;
  logic       RW_bus;
  logic [7:0] Data_in;
  logic [7:0] Data_out;
  logic       Data_oe;

  modport master (
    output Access,
    output Add_bus,
    output RW_bus,
    output Data_in,
    input  Data_out,
    input  Data_oe
  );

  modport slave (
    input  Access,
    input  Add_bus,
    input  RW_bus,
    input  Data_in,
    output Data_out,
    output Data_oe
  );
endinterface

// File: rtl/counter_bus_port.sv
// Counter-side bus responder: control word decode, count register assembly and
// output/status latch read sequencing for one counter.
module counter_bus_port #(
  parameter logic [1:0] COUNTER_ID = 2'b00
) (
  input  logic                CLK,
  input  logic                _RESET,
  counter_bus_port_if.slave   bus,
  input  logic [15:0]         CE_value,
  input  logic                Out_pin,
  input  logic                Ce_loaded,
  output logic [15:0]         CR_value,
  output logic                CR_load,
  output logic [2:0]          Mode,
  output logic                BCD,
  output logic [1:0]          RW_mode,
  output logic                Mode_written
);

  // Read-back command carries one select bit per counter in D[3:1].
  localparam logic [2:0] RbSelMask = 3'b001 << COUNTER_ID;

  logic [2:0]  mode_q, mode_d;
  logic        bcd_q, bcd_d;
  logic [1:0]  rw_mode_q, rw_mode_d;
  logic        null_count_q, null_count_d;
  logic        wr_msb_q, wr_msb_d;
  logic        rd_msb_q, rd_msb_d;
  logic        cnt_latched_q, cnt_latched_d;
  logic        sts_latched_q, sts_latched_d;
  logic [15:0] out_latch_q, out_latch_d;
  logic [7:0]  sts_latch_q, sts_latch_d;
  logic [15:0] cr_q, cr_d;
  logic        cr_load_q, cr_load_d;
  logic        mode_written_q, mode_written_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;

  logic        sel_cnt, sel_cw;
  logic        cw_prog, cw_latch, cw_rb;
  logic        latch_cnt, latch_sts;
  logic        acc_wr, acc_rd;
  logic [15:0] rd_src;

  always_comb begin
    sel_cnt   = bus.Access && (bus.Add_bus == COUNTER_ID);
    sel_cw    = bus.Access && (bus.Add_bus == 2'b11) && !bus.RW_bus;
    cw_prog   = sel_cw && (bus.Data_in[7:6] == COUNTER_ID) && (bus.Data_in[5:4] != 2'b00);
    cw_latch  = sel_cw && (bus.Data_in[7:6] == COUNTER_ID) && (bus.Data_in[5:4] == 2'b00);
    cw_rb     = sel_cw && (bus.Data_in[7:6] == 2'b11) && |(bus.Data_in[3:1] & RbSelMask);
    latch_cnt = (cw_latch || (cw_rb && !bus.Data_in[5])) && !cnt_latched_q;
    latch_sts = cw_rb && !bus.Data_in[4] && !sts_latched_q;
    acc_wr    = sel_cnt && !bus.RW_bus;
    acc_rd    = sel_cnt && bus.RW_bus;
    rd_src    = cnt_latched_q ? out_latch_q : CE_value;
  end

  always_comb begin
    mode_d         = mode_q;
    bcd_d          = bcd_q;
    rw_mode_d      = rw_mode_q;
    wr_msb_d       = wr_msb_q;
    rd_msb_d       = rd_msb_q;
    cnt_latched_d  = cnt_latched_q;
    sts_latched_d  = sts_latched_q;
    out_latch_d    = out_latch_q;
    sts_latch_d    = sts_latch_q;
    cr_d           = cr_q;
    cr_load_d      = 1'b0;
    mode_written_d = 1'b0;
    data_out_d     = data_out_q;
    data_oe_d      = 1'b0;

    if (cw_prog) begin
      rw_mode_d      = bus.Data_in[5:4];
      // Modes 6 and 7 alias to 2 and 3.
      mode_d         = {bus.Data_in[3] & ~bus.Data_in[2], bus.Data_in[2:1]};
      bcd_d          = bus.Data_in[0];
      wr_msb_d       = 1'b0;
      rd_msb_d       = 1'b0;
      cnt_latched_d  = 1'b0;
      sts_latched_d  = 1'b0;
      mode_written_d = 1'b1;
    end else if (cw_latch || cw_rb) begin
      if (latch_cnt) begin
        out_latch_d   = CE_value;
        cnt_latched_d = 1'b1;
      end
      if (latch_sts) begin
        sts_latch_d   = {Out_pin, null_count_q, rw_mode_q, mode_q, bcd_q};
        sts_latched_d = 1'b1;
      end
    end else if (acc_wr) begin
      unique case (rw_mode_q)
        2'b01: begin
          cr_d      = {8'h00, bus.Data_in};
          cr_load_d = 1'b1;
        end
        2'b10: begin
          cr_d      = {bus.Data_in, 8'h00};
          cr_load_d = 1'b1;
        end
        2'b11: begin
          if (!wr_msb_q) begin
            cr_d[7:0] = bus.Data_in;
            wr_msb_d  = 1'b1;
          end else begin
            cr_d[15:8] = bus.Data_in;
            cr_load_d  = 1'b1;
            wr_msb_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (acc_rd) begin
      data_oe_d = 1'b1;
      if (sts_latched_q) begin
        data_out_d    = sts_latch_q;
        sts_latched_d = 1'b0;
      end else begin
        unique case (rw_mode_q)
          2'b01: begin
            data_out_d    = rd_src[7:0];
            cnt_latched_d = 1'b0;
          end
          2'b10: begin
            data_out_d    = rd_src[15:8];
            cnt_latched_d = 1'b0;
          end
          2'b11: begin
            if (!rd_msb_q) begin
              data_out_d = rd_src[7:0];
              rd_msb_d   = 1'b1;
            end else begin
              data_out_d    = rd_src[15:8];
              rd_msb_d      = 1'b0;
              cnt_latched_d = 1'b0;
            end
          end
          default: data_out_d = 8'h00;
        endcase
      end
    end

    // A new count or mode outranks a simultaneous load acknowledge.
    if (cr_load_d || cw_prog) begin
      null_count_d = 1'b1;
    end else if (Ce_loaded) begin
      null_count_d = 1'b0;
    end else begin
      null_count_d = null_count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      mode_q         <= 3'd0;
      bcd_q          <= 1'b0;
      rw_mode_q      <= 2'b00;
      null_count_q   <= 1'b0;
      wr_msb_q       <= 1'b0;
      rd_msb_q       <= 1'b0;
      cnt_latched_q  <= 1'b0;
      sts_latched_q  <= 1'b0;
      out_latch_q    <= 16'h0000;
      sts_latch_q    <= 8'h00;
      cr_q           <= 16'h0000;
      cr_load_q      <= 1'b0;
      mode_written_q <= 1'b0;
      data_out_q     <= 8'h00;
      data_oe_q      <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      bcd_q          <= bcd_d;
      rw_mode_q      <= rw_mode_d;
      null_count_q   <= null_count_d;
      wr_msb_q       <= wr_msb_d;
      rd_msb_q       <= rd_msb_d;
      cnt_latched_q  <= cnt_latched_d;
      sts_latched_q  <= sts_latched_d;
      out_latch_q    <= out_latch_d;
      sts_latch_q    <= sts_latch_d;
      cr_q           <= cr_d;
      cr_load_q      <= cr_load_d;
      mode_written_q <= mode_written_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
    end
  end

  assign bus.Data_out  = data_out_q;
  assign bus.Data_oe   = data_oe_q;
  assign CR_value      = cr_q;
  assign CR_load       = cr_load_q;
  assign Mode          = mode_q;
  assign BCD           = bcd_q;
  assign RW_mode       = rw_mode_q;
  assign Mode_written  = mode_written_q;

endmodule
